// File: rtl/sq_meta_cxt_fetcher_pkg.sv
// Shared context-engine protocol constants, the ingress head layout and the
// CXT_READ head builder used by the SQ context-fetch thread.
package sq_meta_cxt_fetcher_pkg;

  localparam int QP_NUM_LOG                    = 24;
  localparam int MAX_QP_NUM_LOG                = 24;
  localparam int MAX_OOO_SLOT_NUM_LOG          = 8;
  localparam int CXT_OP_WIDTH                  = 4;
  localparam logic [CXT_OP_WIDTH-1:0] CXT_READ = 4'h1;
  localparam logic NO_BYPASS                   = 1'b0;

  localparam int INGRESS_COMMON_HEAD_WIDTH =
    QP_NUM_LOG + CXT_OP_WIDTH + 1 + MAX_OOO_SLOT_NUM_LOG;
  localparam int SQ_OOO_CXT_INGRESS_HEAD_WIDTH = INGRESS_COMMON_HEAD_WIDTH + MAX_QP_NUM_LOG;
  localparam int SQ_OOO_CXT_INGRESS_DATA_WIDTH = 128;

  typedef struct packed {
    logic [QP_NUM_LOG-1:0]           qpn;
    logic [CXT_OP_WIDTH-1:0]         op;
    logic                            bypass;
    logic [MAX_OOO_SLOT_NUM_LOG-1:0] slot_count;
    logic [MAX_QP_NUM_LOG-1:0]       queue_index;
  } cxt_head_t;

  function automatic cxt_head_t packCxtRead(input logic [QP_NUM_LOG-1:0] qpn);
    cxt_head_t h;
    h.qpn         = qpn;
    h.op          = CXT_READ;
    h.bypass      = NO_BYPASS;
    h.slot_count  = MAX_OOO_SLOT_NUM_LOG'(1);
    h.queue_index = MAX_QP_NUM_LOG'(qpn);
    return h;
  endfunction

endpackage

// File: rtl/sq_qpn_fifo.sv
// Register FIFO of QPNs exposing head, tail, occupancy flags and count;
// push and pop may happen in the same cycle.
module sq_qpn_fifo
  import sq_meta_cxt_fetcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = QP_NUM_LOG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_tail,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_tail_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_count == CNT_W'(0));
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign w_tail_ptr = r_wr_ptr - PTR_W'(1);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_tail     = r_mem[w_tail_ptr];

  // Storage needs no reset: empty/count gate every consumer of the entries.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap on plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sq_meta_cxt_fetcher.sv
// SQ context-fetch thread: queues QPNs, merges back-to-back duplicates and
// issues single-beat CXT_READ requests under an outstanding-read credit limit.
module sq_meta_cxt_fetcher
  import sq_meta_cxt_fetcher_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter bit MERGE_EN        = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     qpn_valid,
  input  logic [23:0]                              qpn_data,
  output logic                                     qpn_ready,
  output logic                                     fetch_cxt_ingress_valid,
  output logic [SQ_OOO_CXT_INGRESS_HEAD_WIDTH-1:0] fetch_cxt_ingress_head,
  output logic [SQ_OOO_CXT_INGRESS_DATA_WIDTH-1:0] fetch_cxt_ingress_data,
  output logic                                     fetch_cxt_ingress_start,
  output logic                                     fetch_cxt_ingress_last,
  input  logic                                     fetch_cxt_ingress_ready,
  input  logic                                     cxt_resp_done,
  output logic [7:0]                               credit_avail,
  output logic [15:0]                              merge_cnt,
  output logic                                     credit_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] CREDIT_MAX = 8'(MAX_OUTSTANDING);

  logic [QP_NUM_LOG-1:0] w_head_qpn;
  logic [QP_NUM_LOG-1:0] w_tail_qpn;
  logic                  w_empty;
  logic                  w_full;
  logic [CNT_W-1:0]      w_count;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_accept;
  logic                  w_merge_hit;
  logic                  w_resp_ok;
  logic [7:0]            r_credit;
  logic [15:0]           r_merge_cnt;
  logic                  r_credit_err;

  sq_qpn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (QP_NUM_LOG)
  ) u_qpn_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (qpn_data[QP_NUM_LOG-1:0]),
    .i_pop       (w_pop),
    .o_head      (w_head_qpn),
    .o_tail      (w_tail_qpn),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_count     (w_count)
  );

  assign fetch_cxt_ingress_valid = !w_empty && (r_credit != 8'd0);
  assign fetch_cxt_ingress_start = fetch_cxt_ingress_valid;
  assign fetch_cxt_ingress_last  = fetch_cxt_ingress_valid;
  assign fetch_cxt_ingress_data  = '0;
  assign fetch_cxt_ingress_head  = fetch_cxt_ingress_valid ? packCxtRead(w_head_qpn) : '0;
  assign w_pop = fetch_cxt_ingress_valid && fetch_cxt_ingress_ready;

  // A merge into the sole entry being popped this cycle would lose the QPN, so it is blocked.
  assign w_merge_hit = MERGE_EN && !w_empty && (qpn_data[QP_NUM_LOG-1:0] == w_tail_qpn) &&
                       !(w_pop && (w_count == CNT_W'(1)));
  assign qpn_ready   = !w_full || w_merge_hit;
  assign w_accept    = qpn_valid && qpn_ready;
  assign w_push      = w_accept && !w_merge_hit;
  assign w_resp_ok   = cxt_resp_done && (r_credit != CREDIT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_credit     <= CREDIT_MAX;
      r_merge_cnt  <= '0;
      r_credit_err <= 1'b0;
    end else begin
      if (w_pop && !w_resp_ok)      r_credit <= r_credit - 8'd1;
      else if (w_resp_ok && !w_pop) r_credit <= r_credit + 8'd1;
      if (cxt_resp_done && (r_credit == CREDIT_MAX)) r_credit_err <= 1'b1;
      if (w_accept && w_merge_hit && (r_merge_cnt != 16'hFFFF)) r_merge_cnt <= r_merge_cnt + 16'd1;
    end
  end

  assign credit_avail = r_credit;
  assign merge_cnt    = r_merge_cnt;
  assign credit_err   = r_credit_err;

endmodule

// File: tb/tb_sq_meta_cxt_fetcher.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a queue-based reference model of the fetch thread.
module tb_sq_meta_cxt_fetcher;
  import sq_meta_cxt_fetcher_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
  localparam bit MERGE = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        qpn_valid;
  logic [23:0] qpn_data;
  logic        qpn_ready;
  logic        fetch_cxt_ingress_valid;
  logic [SQ_OOO_CXT_INGRESS_HEAD_WIDTH-1:0] fetch_cxt_ingress_head;
  logic [SQ_OOO_CXT_INGRESS_DATA_WIDTH-1:0] fetch_cxt_ingress_data;
  logic        fetch_cxt_ingress_start;
  logic        fetch_cxt_ingress_last;
  logic        fetch_cxt_ingress_ready;
  logic        cxt_resp_done;
  logic [7:0]  credit_avail;
  logic [15:0] merge_cnt;
  logic        credit_err;

  sq_meta_cxt_fetcher #(
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .MERGE_EN        (MERGE)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .qpn_valid               (qpn_valid),
    .qpn_data                (qpn_data),
    .qpn_ready               (qpn_ready),
    .fetch_cxt_ingress_valid (fetch_cxt_ingress_valid),
    .fetch_cxt_ingress_head  (fetch_cxt_ingress_head),
    .fetch_cxt_ingress_data  (fetch_cxt_ingress_data),
    .fetch_cxt_ingress_start (fetch_cxt_ingress_start),
    .fetch_cxt_ingress_last  (fetch_cxt_ingress_last),
    .fetch_cxt_ingress_ready (fetch_cxt_ingress_ready),
    .cxt_resp_done           (cxt_resp_done),
    .credit_avail            (credit_avail),
    .merge_cnt               (merge_cnt),
    .credit_err              (credit_err)
  );

  always #5 clk = ~clk;

  logic [23:0] mQueue[$];
  int          mCredit;
  int          mMergeCnt;
  bit          mErr;
  int          total = 0;
  int          bad   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Head layout from the interface definition: {qpn, op, bypass, slot_count, queue_index}.
  function automatic logic [63:0] expHead(input logic [23:0] q);
    logic [60:0] h;
    h = {q, CXT_READ, NO_BYPASS, 8'd1, q};
    return 64'(h);
  endfunction

  task automatic modelReset();
    mQueue.delete();
    mCredit   = MAXO;
    mMergeCnt = 0;
    mErr      = 1'b0;
  endtask

  // One cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic applyStimulus(input bit rst, input bit v, input logic [23:0] d,
                               input bit rdy, input bit resp);
    bit expValid, expPop, mergeHit, expReady, respOk;
    @(negedge clk);
    rst_n = !rst;
    qpn_valid = v;
    qpn_data = d;
    fetch_cxt_ingress_ready = rdy;
    cxt_resp_done = resp;
    #1;
    expValid = (mQueue.size() > 0) && (mCredit != 0);
    expPop   = expValid && rdy;
    mergeHit = MERGE && (mQueue.size() > 0) && (d == mQueue[$]) && !(expPop && mQueue.size() == 1);
    expReady = (mQueue.size() < DEPTH) || mergeHit;
    checkOutput("valid", 64'(fetch_cxt_ingress_valid), 64'(expValid));
    checkOutput("start", 64'(fetch_cxt_ingress_start), 64'(expValid));
    checkOutput("last", 64'(fetch_cxt_ingress_last), 64'(expValid));
    checkOutput("head", 64'(fetch_cxt_ingress_head), expValid ? expHead(mQueue[0]) : 64'd0);
    checkOutput("data", 64'(|fetch_cxt_ingress_data), 64'd0);
    checkOutput("qpn_ready", 64'(qpn_ready), 64'(expReady));
    checkOutput("credit", 64'(credit_avail), 64'(mCredit));
    checkOutput("merge_cnt", 64'(merge_cnt), 64'(mMergeCnt));
    checkOutput("credit_err", 64'(credit_err), 64'(mErr));
    if (rst) begin
      modelReset();
    end else begin
      respOk = resp && (mCredit != MAXO);
      if (resp && mCredit == MAXO) mErr = 1'b1;
      if (expPop) void'(mQueue.pop_front());
      if (v && expReady) begin
        if (mergeHit) begin
          if (mMergeCnt != 16'hFFFF) mMergeCnt++;
        end else begin
          mQueue.push_back(d);
        end
      end
      if (expPop && !respOk) mCredit--;
      else if (respOk && !expPop) mCredit++;
    end
  endtask

  initial begin
    logic [23:0] rq;
    int respDiv;
    rst_n = 1'b0;
    qpn_valid = 1'b0;
    qpn_data = '0;
    fetch_cxt_ingress_ready = 1'b0;
    cxt_resp_done = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();

    applyStimulus(1, 0, 24'h0, 0, 0);
    applyStimulus(0, 1, 24'h000123, 1, 0);
    checkOutput("rst_credit", 64'(credit_avail), 64'd8);
    checkOutput("rst_valid", 64'(fetch_cxt_ingress_valid), 64'd0);
    applyStimulus(0, 0, 24'h0, 1, 0);
    checkOutput("t1_head_qpn", 64'(fetch_cxt_ingress_head[60:37]), 64'h123);
    applyStimulus(0, 0, 24'h0, 1, 0);
    checkOutput("t1_credit", 64'(credit_avail), 64'd7);
    checkOutput("t1_one_beat", 64'(fetch_cxt_ingress_valid), 64'd0);

    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 24'h000200 + 24'(i), 0, 0);
    checkOutput("fill_full", 64'(qpn_ready), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 24'h0, 1, 0);

    applyStimulus(0, 1, 24'h000007, 0, 0);
    applyStimulus(0, 1, 24'h000007, 0, 0);
    applyStimulus(0, 0, 24'h0, 0, 0);
    checkOutput("merge_one", 64'(merge_cnt), 64'd1);
    applyStimulus(0, 0, 24'h0, 1, 1);
    applyStimulus(0, 0, 24'h0, 1, 0);
    checkOutput("merge_drained", 64'(fetch_cxt_ingress_valid), 64'd0);

    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 24'h0, 0, 1);
    checkOutput("err_credit", 64'(credit_avail), 64'd8);
    applyStimulus(0, 0, 24'h0, 0, 1);
    checkOutput("err_set", 64'(credit_err), 64'd1);

    applyStimulus(0, 1, 24'h000031, 0, 0);
    applyStimulus(0, 1, 24'h000032, 1, 0);
    applyStimulus(0, 1, 24'h000033, 1, 0);
    applyStimulus(0, 1, 24'h000034, 0, 0);
    applyStimulus(1, 0, 24'h0, 1, 0);
    applyStimulus(0, 0, 24'h0, 1, 0);
    checkOutput("midrst_valid", 64'(fetch_cxt_ingress_valid), 64'd0);
    checkOutput("midrst_credit", 64'(credit_avail), 64'd8);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rq = 24'h000007;
        1: rq = 24'h800007;
        2: rq = 24'h000123;
        default: rq = 24'($urandom());
      endcase
      respDiv = (i < 1500) ? 1 : 5;
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rq,
                    $urandom_range(0, 3) != 0, $urandom_range(0, respDiv) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
